// File: rtl/heap_pq_if.sv
// heap_pq_if: command/status bundle of the heap priority queue.
// master drives start, instruction and key; slave returns ready, done, err, dout, top, count, empty and full.
interface heap_pq_if #(
    parameter int KEY_W = 32,
    parameter int DEPTH = 1024
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    logic             start;
    logic [1:0]       instruction;
    logic [KEY_W-1:0] key;
    logic             ready;
    logic             done;
    logic             err;
    logic [KEY_W-1:0] dout;
    logic [KEY_W-1:0] top;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    modport master (
        output start, instruction, key,
        input  ready, done, err, dout, top, count, empty, full
    );
    modport slave (
        input  start, instruction, key,
        output ready, done, err, dout, top, count, empty, full
    );
endinterface

// File: rtl/heap_pq.sv
// heap_pq: binary-heap priority queue with one compare/swap per cycle.
// Ports: clk, reset_n (async, active low), bus (heap_pq_if.slave): start/instruction/key in;
// ready/done/err/dout/top/count/empty/full out.
module heap_pq #(
    parameter int KEY_W    = 32,
    parameter int DEPTH    = 1024,
    parameter int MIN_MODE = 0
) (
    input logic       clk,
    input logic       reset_n,
    heap_pq_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int IW    = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN, DONE} state_t;
    state_t           state, state_nxt;
    logic [KEY_W-1:0] arr [DEPTH];
    logic [CNT_W-1:0] cnt, cnt_m1, count_q;
    logic [IW-1:0]    idx, parent, best, left_i, right_i;
    logic [CNT_W:0]   left_n, right_n;
    logic [KEY_W-1:0] key_left, dout_q, top_q;
    logic             take_left, take_right, up_swap, dn_swap;
    logic             is_nop, is_push, is_pop, empty_now, full_now, reject, go, err_nxt;
    logic             err_q, empty_q, full_q;
    function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        return (MIN_MODE != 0) ? (a < b) : (a > b);
    endfunction
    assign is_nop    = bus.instruction == 2'b00;
    assign is_push   = bus.instruction == 2'b01;
    assign is_pop    = bus.instruction == 2'b10;
    assign empty_now = cnt == '0;
    assign full_now  = cnt == CNT_W'(DEPTH);
    assign cnt_m1    = cnt - 1'b1;
    assign reject    = (is_push && full_now) || (bus.instruction[1] && empty_now);
    assign go        = state == IDLE && bus.start && !is_nop && !reject;
    assign err_nxt   = state == IDLE && reject;
    assign parent    = (idx - 1'b1) >> 1;
    assign up_swap   = idx != '0 && better(arr[idx], arr[parent]);
    // Child indices are one bit wider than cnt so 2*idx+2 cannot wrap past DEPTH.
    assign left_n    = {1'b0, idx, 1'b1};
    assign right_n   = left_n + 1'b1;
    assign left_i    = left_n[IW-1:0];
    assign right_i   = right_n[IW-1:0];
    // Strict compares keep the parent on ties, and the left child wins a tie between children.
    assign take_left  = left_n < {1'b0, cnt} && better(arr[left_i], arr[idx]);
    assign key_left   = take_left ? arr[left_i] : arr[idx];
    assign take_right = right_n < {1'b0, cnt} && better(arr[right_i], key_left);
    assign best       = take_right ? right_i : take_left ? left_i : idx;
    assign dn_swap    = take_left || take_right;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = !bus.start ? IDLE : (is_nop || reject) ? DONE : is_push ? SIFT_UP : SIFT_DOWN;
            SIFT_UP:   state_nxt = up_swap ? SIFT_UP : DONE;
            SIFT_DOWN: state_nxt = dn_swap ? SIFT_DOWN : DONE;
            default:   state_nxt = IDLE;
        endcase
    end
    // Heap storage carries no reset; entries at or above count are never observed.
    always_ff @(posedge clk) begin
        if (go) begin
            if (is_push) arr[cnt[IW-1:0]] <= bus.key;
            else arr[0] <= is_pop ? arr[cnt_m1[IW-1:0]] : bus.key;
        end
        if (state == SIFT_UP && up_swap) begin
            arr[idx]    <= arr[parent];
            arr[parent] <= arr[idx];
        end
        if (state == SIFT_DOWN && dn_swap) begin
            arr[idx]  <= arr[best];
            arr[best] <= arr[idx];
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            top_q   <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (go) begin
                cnt <= is_push ? cnt + 1'b1 : is_pop ? cnt_m1 : cnt;
                idx <= is_push ? cnt[IW-1:0] : '0;
                if (!is_push) dout_q <= arr[0];
            end
            if (state == SIFT_UP && up_swap) idx <= parent;
            if (state == SIFT_DOWN && dn_swap) idx <= best;
            // Entering DONE means no swap this cycle, so arr[0] and cnt already hold final values.
            if (state_nxt == DONE) begin
                err_q   <= err_nxt;
                top_q   <= empty_now ? '0 : arr[0];
                count_q <= cnt;
                empty_q <= empty_now;
                full_q  <= full_now;
            end
        end
    end
    assign bus.ready = state == IDLE;
    assign bus.done  = state == DONE;
    assign bus.err   = err_q;
    assign bus.dout  = dout_q;
    assign bus.top   = top_q;
    assign bus.count = count_q;
    assign bus.empty = empty_q;
    assign bus.full  = full_q;
endmodule

// File: tb/tb_heap_pq.sv
// tb_heap_pq: drives a max-heap and a min-heap instance with identical commands and checks both against multiset models.
module tb_heap_pq;
    localparam int KEY_W = 8;
    localparam int DEPTH = 8;
    typedef logic [KEY_W-1:0] kq_t[$];
    logic             clk;
    logic             reset_n;
    logic             start;
    logic [1:0]       instruction;
    logic [KEY_W-1:0] key;
    int               checks;
    int               errors;
    int               lat0, lat1;
    kq_t              q0, q1;
    logic [KEY_W-1:0] ld0, ld1;
    logic             c_err [2];
    logic [KEY_W-1:0] c_dout [2];
    logic [KEY_W-1:0] c_top [2];
    logic [3:0]       c_cnt [2];
    logic             c_emp [2];
    logic             c_full [2];
    heap_pq_if #(.KEY_W(KEY_W), .DEPTH(DEPTH)) bus0 ();
    heap_pq_if #(.KEY_W(KEY_W), .DEPTH(DEPTH)) bus1 ();
    assign bus0.start = start;
    assign bus0.instruction = instruction;
    assign bus0.key = key;
    assign bus1.start = start;
    assign bus1.instruction = instruction;
    assign bus1.key = key;
    heap_pq #(.KEY_W(KEY_W), .DEPTH(DEPTH), .MIN_MODE(0)) u_max (.clk(clk), .reset_n(reset_n), .bus(bus0));
    heap_pq #(.KEY_W(KEY_W), .DEPTH(DEPTH), .MIN_MODE(1)) u_min (.clk(clk), .reset_n(reset_n), .bus(bus1));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic int best_idx(kq_t q, bit mm);
        int b = 0;
        for (int i = 1; i < q.size(); i++)
            if (mm ? q[i] < q[b] : q[i] > q[b]) b = i;
        return b;
    endfunction
    function automatic logic [KEY_W-1:0] exp_top(kq_t q, bit mm);
        if (q.size() == 0) return '0;
        return q[best_idx(q, mm)];
    endfunction
    task automatic model_step(inout kq_t q, input bit mm, input logic [1:0] ins, input logic [KEY_W-1:0] k,
                              inout logic [KEY_W-1:0] last, output logic e);
        int b;
        e = 1'b0;
        if (ins == 2'b01) begin
            if (q.size() == DEPTH) e = 1'b1;
            else q.push_back(k);
        end else if (ins[1]) begin
            if (q.size() == 0) e = 1'b1;
            else begin
                b = best_idx(q, mm);
                last = q[b];
                q.delete(b);
                if (ins == 2'b11) q.push_back(k);
            end
        end
    endtask
    task automatic cmp(input string p, input int i, input kq_t q, input bit mm, input logic [KEY_W-1:0] ld, input logic e);
        check({p, "_err"}, c_err[i], e);
        check({p, "_dout"}, c_dout[i], ld);
        check({p, "_top"}, c_top[i], exp_top(q, mm));
        check({p, "_count"}, c_cnt[i], q.size());
        check({p, "_empty"}, c_emp[i], q.size() == 0);
        check({p, "_full"}, c_full[i], q.size() == DEPTH);
    endtask
    task automatic idle_chk(input string p, input logic r, input logic d, input logic e, input logic [KEY_W-1:0] o,
                            input logic [KEY_W-1:0] t, input logic [3:0] c, input logic em, input logic fu);
        check({p, "_rst_ready"}, r, 1);
        check({p, "_rst_done"}, d, 0);
        check({p, "_rst_err"}, e, 0);
        check({p, "_rst_dout"}, o, 0);
        check({p, "_rst_top"}, t, 0);
        check({p, "_rst_count"}, c, 0);
        check({p, "_rst_empty"}, em, 1);
        check({p, "_rst_full"}, fu, 0);
    endtask
    // Issues one command to both instances; optionally keeps start high while busy to show it is ignored.
    task automatic do_cmd(input logic [1:0] ins, input logic [KEY_W-1:0] k, input bit hold);
        int   n;
        bit   d0, d1;
        logic e0, e1;
        model_step(q0, 1'b0, ins, k, ld0, e0);
        model_step(q1, 1'b1, ins, k, ld1, e1);
        start = 1'b1;
        instruction = ins;
        key = k;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        n = 1;
        d0 = 1'b0;
        d1 = 1'b0;
        lat0 = 0;
        lat1 = 0;
        while (!(d0 && d1) && n < 20) begin
            if (!d0 && bus0.done) begin
                d0 = 1'b1; lat0 = n; start = 1'b0;
                c_err[0] = bus0.err; c_dout[0] = bus0.dout; c_top[0] = bus0.top;
                c_cnt[0] = bus0.count; c_emp[0] = bus0.empty; c_full[0] = bus0.full;
            end
            if (!d1 && bus1.done) begin
                d1 = 1'b1; lat1 = n; start = 1'b0;
                c_err[1] = bus1.err; c_dout[1] = bus1.dout; c_top[1] = bus1.top;
                c_cnt[1] = bus1.count; c_emp[1] = bus1.empty; c_full[1] = bus1.full;
            end
            if (!(d0 && d1)) begin
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        check("max_done_seen", d0, 1);
        check("min_done_seen", d1, 1);
        cmp("max", 0, q0, 1'b0, ld0, e0);
        cmp("min", 1, q1, 1'b1, ld1, e1);
        @(posedge clk); #1;
        check("max_ready_after", bus0.ready, 1);
        check("min_ready_after", bus1.ready, 1);
        check("max_err_hold", bus0.err, e0);
        check("min_err_hold", bus1.err, e1);
    endtask
    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        start = 1'b0;
        instruction = 2'b00;
        key = '0;
        ld0 = '0;
        ld1 = '0;
        repeat (2) @(posedge clk);
        #1;
        idle_chk("max", bus0.ready, bus0.done, bus0.err, bus0.dout, bus0.top, bus0.count, bus0.empty, bus0.full);
        idle_chk("min", bus1.ready, bus1.done, bus1.err, bus1.dout, bus1.top, bus1.count, bus1.empty, bus1.full);
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_cmd(2'b01, 8'd10, 1'b0);
        check("max_lat_push_empty", lat0, 2);
        check("min_lat_push_empty", lat1, 2);
        do_cmd(2'b00, 8'd0, 1'b0);
        check("max_lat_nop", lat0, 1);
        do_cmd(2'b10, 8'd0, 1'b0);
        for (int k = 1; k <= 7; k++) do_cmd(2'b01, 8'(k), 1'b0);
        do_cmd(2'b01, 8'd8, 1'b0);
        check("max_lat_push8", lat0, 5);
        check("min_lat_push8", lat1, 2);
        do_cmd(2'b01, 8'd42, 1'b0);
        check("max_full_err", c_err[0], 1);
        check("max_full_top", c_top[0], 8);
        for (int k = 0; k < 8; k++) do_cmd(2'b10, 8'd0, 1'b0);
        do_cmd(2'b10, 8'd0, 1'b0);
        check("max_empty_pop_err", c_err[0], 1);
        check("max_empty_pop_dout", c_dout[0], 1);
        do_cmd(2'b01, 8'd5, 1'b0);
        do_cmd(2'b01, 8'd3, 1'b0);
        do_cmd(2'b01, 8'd9, 1'b0);
        do_cmd(2'b01, 8'd1, 1'b0);
        do_cmd(2'b01, 8'd7, 1'b0);
        check("max_top_5", c_top[0], 9);
        for (int k = 0; k < 5; k++) do_cmd(2'b10, 8'd0, 1'b0);
        do_cmd(2'b01, 8'd9, 1'b0);
        do_cmd(2'b01, 8'd7, 1'b0);
        do_cmd(2'b01, 8'd5, 1'b0);
        do_cmd(2'b11, 8'd4, 1'b0);
        check("max_replace_dout", c_dout[0], 9);
        check("max_replace_top", c_top[0], 7);
        for (int k = 0; k < 3; k++) do_cmd(2'b10, 8'd0, 1'b0);
        do_cmd(2'b01, 8'd5, 1'b0);
        do_cmd(2'b01, 8'd3, 1'b0);
        do_cmd(2'b01, 8'd9, 1'b0);
        do_cmd(2'b01, 8'd3, 1'b1);
        check("min_top_ties", c_top[1], 3);
        for (int k = 0; k < 4; k++) do_cmd(2'b10, 8'd0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [1:0] ins;
            r = $urandom_range(0, 9);
            if ((n / 50) % 2 == 0) ins = r == 0 ? 2'b00 : r < 6 ? 2'b01 : r < 8 ? 2'b10 : 2'b11;
            else ins = r == 0 ? 2'b00 : r < 3 ? 2'b01 : r < 8 ? 2'b10 : 2'b11;
            do_cmd(ins, 8'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        while (q0.size() < 4) do_cmd(2'b01, 8'($urandom_range(0, 15)), 1'b0);
        start = 1'b1;
        instruction = 2'b10;
        @(posedge clk); #1;
        start = 1'b0;
        check("max_in_sift", bus0.ready, 0);
        reset_n = 1'b0;
        #1;
        idle_chk("max", bus0.ready, bus0.done, bus0.err, bus0.dout, bus0.top, bus0.count, bus0.empty, bus0.full);
        idle_chk("min", bus1.ready, bus1.done, bus1.err, bus1.dout, bus1.top, bus1.count, bus1.empty, bus1.full);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("max_no_done_rst", bus0.done, 0);
            check("min_no_done_rst", bus1.done, 0);
        end
        reset_n = 1'b1;
        q0.delete();
        q1.delete();
        ld0 = '0;
        ld1 = '0;
        @(posedge clk); #1;
        check("max_no_done_rel", bus0.done, 0);
        check("max_ready_rel", bus0.ready, 1);
        do_cmd(2'b01, 8'd6, 1'b0);
        check("max_top_after_rst", c_top[0], 6);
        check("max_count_after_rst", c_cnt[0], 1);
        check("min_top_after_rst", c_top[1], 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/heap_pq.md
HEAP_PQ -- requirements
Module: heap_pq

Interface
REQ-001 The block SHALL have parameter KEY_W, default 32, meaning key width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning maximum number of stored keys; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter MIN_MODE, default 0, meaning 0 = max-heap (largest key at top) and 1 = min-heap.
REQ-004 The block SHALL define CNT_W = clog2(DEPTH)+1 as a local width, not an overridable parameter.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  command strobe; sampled only while ready=1.
REQ-008 instruction  input  2  00 no-op, 01 push, 10 pop, 11 replace (pop top, then insert key).
REQ-009 key  input  KEY_W  key for push/replace; sampled with start.
REQ-010 ready  output  1  high in IDLE only.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  valid with done; 1 = command rejected.
REQ-013 dout  output  KEY_W  key removed by the last successful pop/replace.
REQ-014 top  output  KEY_W  current root key; 0 when empty.
REQ-015 count  output  CNT_W  number of stored keys.
REQ-016 empty, full  output  1 each  count==0 and count==DEPTH respectively.

Function
REQ-017 The FSM SHALL have states IDLE, SIFT_UP, SIFT_DOWN and DONE; ready=1 only in IDLE, and done=1 only in DONE.
REQ-018 In IDLE with start=1, push SHALL write key to arr[count], increment count, set idx=old count, and go to SIFT_UP.
REQ-019 SIFT_UP SHALL do one compare per cycle: if idx==0 or arr[idx] is not strictly better than arr[(idx-1)/2], go to DONE; else swap the two, set idx=parent, and stay.
REQ-020 Pop SHALL load dout with arr[0], move arr[count-1] to arr[0], decrement count, set idx=0, and go to SIFT_DOWN.
REQ-021 Replace SHALL load dout with arr[0], write key to arr[0], leave count unchanged, set idx=0, and go to SIFT_DOWN.
REQ-022 SIFT_DOWN SHALL do one compare per cycle: pick the best of idx, 2idx+1 and 2idx+2, considering children only if their index < count. If best==idx, go to DONE; else swap, set idx=best, and stay.
REQ-023 "Better" SHALL mean unsigned greater-than when MIN_MODE=0 and unsigned less-than when MIN_MODE=1; equal keys SHALL never swap.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-025 A no-op with start=1 SHALL go straight to DONE with err=0 and no state change.
REQ-026 Push when full, or pop/replace when empty, SHALL go straight to DONE with err=1; arr, count and dout are unchanged.
REQ-027 Latency SHALL be: done high 2 cycles after the start-sampling edge for a zero-swap operation, plus 1 cycle per swap; worst case is 2+clog2(DEPTH) cycles.
REQ-028 start while ready=0 SHALL be ignored and SHALL NOT queue.
REQ-029 top, count, empty and full SHALL be registered and SHALL update on the same edge that enters DONE.
REQ-030 err SHALL hold its value until the next done pulse.
REQ-031 Pop that leaves count 0 or 1 SHALL still pass through SIFT_DOWN for exactly one cycle.

Reset
REQ-032 reset_n low SHALL immediately force state=IDLE, count=0, done=0, err=0, dout=0, top=0, empty=1, full=0 and ready=1.
REQ-033 Array contents SHALL NOT be reset; they are unreachable while count=0.
REQ-034 Reset asserted during SIFT_UP or SIFT_DOWN SHALL abort the operation with no done pulse; the first command after release SHALL behave as on an empty heap.

Verification
REQ-035 KEY_W=8, DEPTH=8, MIN_MODE=0: push 5,3,9,1,7 -> top=9, count=5; five pops -> dout 9,7,5,3,1, then empty=1, each with err=0.
REQ-036 Push 8 keys, then push 42 -> err=1, count=8, top unchanged; pop on an empty heap -> err=1, dout holds its last value.
REQ-037 Heap {9,7,5}, replace with key=4 -> dout=9, top=7, count=3; following pops -> 7,5,4.
REQ-038 MIN_MODE=1: push 5,3,9,3 -> top=3; pops -> 3,3,5,9 (ties retained).
REQ-039 Latency: push 10 into an empty heap -> done exactly 2 cycles after start; push 1..7 ascending (MIN_MODE=0), then push 8 -> done 5 cycles after start (3 swaps to root).
REQ-040 Assert reset_n low mid-SIFT_DOWN -> no done pulse, count=0, ready=1; a subsequent push of 6 -> top=6, count=1.
